// File: rtl/countdown_display_mux.sv
// countdown_display_mux
//   Seven-segment driver for the traffic-light countdown timers. Each of NCH
//   binary countdown values is converted to DIGITS decimal digits by a
//   sequential shift-add-3 (double-dabble) engine. Channels are serviced
//   round-robin (LOAD -> SHIFT x WIDTH -> WRITE), and the result is stored as
//   registered active-low segment patterns.
//
// Optional feature:
//   SEG_LZB_EN  when defined, leading zero digits (never digit 0) are blanked.
//
// Ports:
//   CLK         system clock, rising edge
//   RET         synchronous active-high reset
//   VALUE       NCH*WIDTH unsigned values, channel ch at [ch*WIDTH +: WIDTH]
//   BLINK       per-channel blink enable
//   PHASE       blink phase, 0 blanks blinking channels
//   SEG         active-low segments, channel ch digit d at [(ch*DIGITS+d)*8 +: 8]
//   FRAME_DONE  one-cycle pulse on the edge that writes channel NCH-1
module countdown_display_mux #(
    parameter int NCH    = 2,
    parameter int WIDTH  = 5,
    parameter int DIGITS = 2
) (
    input  logic                    CLK,
    input  logic                    RET,
    input  logic [NCH*WIDTH-1:0]    VALUE,
    input  logic [NCH-1:0]          BLINK,
    input  logic                    PHASE,
    output logic [NCH*DIGITS*8-1:0] SEG,
    output logic                    FRAME_DONE
);

    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int unsigned MAXV = (10 ** DIGITS) - 1;

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_WRITE} state_t;

    state_t                  state;
    logic [CH_W-1:0]         ch;
    logic [IT_W-1:0]         iter;
    logic [WIDTH-1:0]        bin_sr;
    logic [BCD_W-1:0]        bcd;
    logic                    ovf;

    logic [WIDTH-1:0]        cur_val;
    logic [BCD_W+WIDTH-1:0]  cat_sh;
    logic [DIGITS*8-1:0]     wr_slice;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int d = 0; d < DIGITS; d++) begin
            if (b[d*4 +: 4] >= 4'd5)
                r[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'd0:    glyph = 8'hC0;
            4'd1:    glyph = 8'hF9;
            4'd2:    glyph = 8'hA4;
            4'd3:    glyph = 8'hB0;
            4'd4:    glyph = 8'h99;
            4'd5:    glyph = 8'h92;
            4'd6:    glyph = 8'h82;
            4'd7:    glyph = 8'hF8;
            4'd8:    glyph = 8'h80;
            4'd9:    glyph = 8'h90;
            default: glyph = 8'hFF;
        endcase
    endfunction

    always_comb begin
        cur_val = VALUE[int'(ch)*WIDTH +: WIDTH];
    end

    // Bits pushed out above the BCD register are dropped; that only happens
    // for values that are flagged as overflow anyway.
    always_comb begin
        cat_sh = {add3(bcd), bin_sr} << 1;
    end

`ifdef SEG_LZB_EN
    logic lead;
`endif

    // Segment pattern for the channel being written; blink beats overflow,
    // overflow beats digits.
    always_comb begin
        wr_slice = '1;
`ifdef SEG_LZB_EN
        lead = 1'b1;
`endif
        for (int d = DIGITS - 1; d >= 0; d--) begin
            wr_slice[d*8 +: 8] = glyph(bcd[d*4 +: 4]);
`ifdef SEG_LZB_EN
            if (d != 0 && lead && bcd[d*4 +: 4] == 4'd0)
                wr_slice[d*8 +: 8] = 8'hFF;
            else
                lead = 1'b0;
`endif
        end
        if (BLINK[ch] && !PHASE)
            wr_slice = '1;
        else if (ovf)
            wr_slice = {DIGITS{8'hBF}};
    end

    always_ff @(posedge CLK) begin
        if (RET) begin
            state      <= S_LOAD;
            ch         <= '0;
            iter       <= '0;
            SEG        <= '1;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= 1'b0;
            case (state)
                S_LOAD: begin
                    bin_sr <= cur_val;
                    bcd    <= '0;
                    ovf    <= (32'(cur_val) > MAXV);
                    iter   <= '0;
                    state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    bcd    <= cat_sh[BCD_W+WIDTH-1:WIDTH];
                    bin_sr <= cat_sh[WIDTH-1:0];
                    iter   <= iter + 1'b1;
                    if (iter == IT_W'(WIDTH - 1))
                        state <= S_WRITE;
                end
                S_WRITE: begin
                    SEG[int'(ch)*DIGITS*8 +: DIGITS*8] <= wr_slice;
                    FRAME_DONE <= (ch == CH_W'(NCH - 1));
                    ch    <= (ch == CH_W'(NCH - 1)) ? '0 : ch + 1'b1;
                    state <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: doc/countdown_display_mux.md
# countdown_display_mux

Parametrised seven-segment driver for the traffic-light countdown timers. It accepts NCH binary countdown values and converts each one to DIGITS decimal digits with a sequential shift-add-3 (double-dabble) engine. Channels are serviced round-robin, and the results are registered as active-low segment patterns. It sits between the countdown counters and the board's segment pins, and adds per-channel blink, overflow indication and a frame-complete strobe.

## Interface
- NCH, 2: number of countdown channels (1–8)
- WIDTH, 5: bits per binary input value (1–16)
- DIGITS, 2: decimal digits per channel (1–5)
- CLK  in  1  system clock, all logic on rising edge
- RET  in  1  synchronous, active-high reset
- VALUE  in  NCH*WIDTH  channel ch at VALUE[ch*WIDTH +: WIDTH], unsigned
- BLINK  in  NCH  per-channel blink enable
- PHASE  in  1  blink phase; 0 = blank blinking channels
- SEG  out  NCH*DIGITS*8  active-low segments; channel ch, digit d (d=0 least significant) at SEG[(ch*DIGITS+d)*8 +: 8]; bit7 = DP
- FRAME_DONE  out  1  one-cycle pulse when all channels have been refreshed

## Operation
- Glyphs (bit7 always 1): 0=0xC0, 1=0xF9, 2=0xA4, 3=0xB0, 4=0x99, 5=0x92, 6=0x82, 7=0xF8, 8=0x80, 9=0x90, blank=0xFF, dash=0xBF.
- FSM states: LOAD → SHIFT → WRITE → LOAD (next channel).
  - LOAD (1 cycle): samples VALUE for the current channel ch into a WIDTH-bit shift register. Clears the 4*DIGITS-bit BCD register. Latches an overflow flag (value > 10^DIGITS−1). Clears the iteration counter.
  - SHIFT (WIDTH cycles): each cycle, every BCD nibble ≥5 is incremented by 3. Then {BCD, bin} is shifted left by 1. Leaves after the WIDTH-th shift.
  - WRITE (1 cycle): updates the SEG slice for ch. Channel index then advances, wrapping NCH−1→0.
- WRITE output priority:
  1. BLINK[ch]=1 and PHASE=0: all digits 0xFF.
  2. Overflow flag: all digits 0xBF.
  3. Otherwise, glyph for each BCD nibble.
- Only the SEG slice of the current channel changes in a WRITE cycle. All other slices hold.
- VALUE changes are seen only at that channel's next LOAD. PHASE and BLINK are sampled only in WRITE.

## Timing
- Reset (RET=1 at an edge):
  - All SEG = 0xFF, FRAME_DONE = 0.
  - FSM goes to LOAD, channel index = 0.
  - This applies in any state, including mid-SHIFT. A partial conversion is discarded, and no SEG slice is written from it.
- First edge with RET=0 executes LOAD for ch0.
- Per-channel latency: WIDTH+2 cycles. Frame period: NCH*(WIDTH+2) cycles. Defaults: 7 and 14.
- SEG slice for ch k is updated by the edge ending WRITE, (k+1)*(WIDTH+2) edges after reset release. Defaults: ch0 at edge 7, ch1 at edge 14.
- FRAME_DONE is a registered signal:
  - Goes 1 on the same edge that writes channel NCH−1.
  - Goes 0 on the next edge.
  - Exactly one pulse per frame.
- Blink response latency: ≤ one frame period.
- Arithmetic:
  - Overflow compare is done at full WIDTH against the constant 10^DIGITS−1. It can never be true when 2^WIDTH−1 ≤ 10^DIGITS−1.
  - The BCD register is exactly 4*DIGITS bits. Bits shifted out above it are discarded, which only happens for overflow values.

## Configuration
- SEG_LZB_EN: leading-zero blanking.
  - Defined: in the WRITE glyph path, a 0 digit that is not d=0 and has only 0 digits above it is output as 0xFF. Digit 0 always shows, so value 0 displays as blank…0xC0.
  - Undefined: all digits are shown, including leading zeros.
  - Blink and overflow priority are unchanged either way.

## Test plan
- Reset and defaults:
  - Stimulus: RET=1 for 3 cycles, VALUE ch0=25, ch1=7, BLINK=0; then release RET.
  - Response: SEG all 0xFF during reset.
  - At edge 7, ch0 = {0xA4, 0x92}.
  - At edge 14, ch1 = {0xC0, 0xF8} (macro undefined) or {0xFF, 0xF8} (macro defined), with FRAME_DONE=1 for exactly that one cycle.
- Full range: sweep ch0 through 0–31 over successive frames → every digit pair matches the decimal glyph table.
- Blink:
  - Stimulus: BLINK=2'b01, PHASE=0, ch0=30.
  - Response: ch0 shows 0xFF, 0xFF at its next WRITE. After setting PHASE=1, it shows {0xB0, 0xC0} within 14 cycles. Ch1 is unaffected throughout.
- Overflow:
  - Stimulus: instance with DIGITS=1, WIDTH=5, VALUE=12.
  - Response: ch0 = 0xBF. With VALUE=9, ch0 = 0x90. With BLINK=1, PHASE=0, it shows 0xFF over the overflow dash.
- Reset mid-conversion:
  - Stimulus: ch0 changes 25→3; assert RET during the 3rd SHIFT cycle of ch1.
  - Response: SEG goes to all 0xFF immediately. No FRAME_DONE for the aborted frame. After release, ch0 = 03 (or blank/3 with SEG_LZB_EN) at edge 7.
- Sampling window:
  - Stimulus: change VALUE ch0 during ch0's SHIFT.
  - Response: the displayed value is the one sampled at LOAD. The new value appears one frame later.
